// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: loads the reset vector, fetches opcode plus operand bytes,
// holds the instruction for decode and applies jump targets at handshake time.
module fetch_sequencer (
    input  logic        CLOCK_ph2,
    input  logic        rst,
    input  logic [7:0]  PCLin,
    input  logic [7:0]  PCHin,
    input  logic [7:0]  DB_in,
    input  logic        instr_ready,
    input  logic        jump_req,
    input  logic [15:0] jump_addr,
    output logic [7:0]  AB_lo,
    output logic [7:0]  AB_hi,
    output logic        RW,
    output logic        INC_en,
    output logic        PCLin_en,
    output logic        PCHin_en,
    output logic        ADLin_en,
    output logic        ADHin_en,
    output logic [7:0]  ADL,
    output logic [7:0]  ADH,
    output logic        instr_valid,
    output logic [7:0]  opcode,
    output logic [7:0]  operand1,
    output logic [7:0]  operand2,
    output logic [1:0]  instr_len
);

    typedef enum logic [2:0] {
        StVecLo,
        StVecHi,
        StFetchOp,
        StFetchB1,
        StFetchB2,
        StHold
    } state_e;

    localparam logic [15:0] VecAddrLo = 16'hFFFC;
    localparam logic [15:0] VecAddrHi = 16'hFFFD;

    state_e      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  operand1_q, operand1_d;
    logic [7:0]  operand2_q, operand2_d;
    logic [1:0]  len_q, len_d;
    logic [15:0] ab;
    logic [1:0]  db_len;

    // Byte count from the 6502 opcode grid: cc = op[1:0], bbb = op[4:2].
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [2:0] bbb;
        logic [1:0] len;
        bbb = op[4:2];
        len = 2'd2;
        unique case (op[1:0])
            2'b01: begin
                if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
            end
            2'b10: begin
                if (bbb == 3'b010 || bbb == 3'b100 || bbb == 3'b110) len = 2'd1;
                else if (bbb == 3'b011 || bbb == 3'b111) len = 2'd3;
            end
            2'b00: begin
                if (bbb == 3'b000) begin
                    if (op == 8'h20) len = 2'd3;
                    else if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
                end else if (bbb == 3'b011 || bbb == 3'b111) begin
                    len = 2'd3;
                end else if (bbb == 3'b010 || bbb == 3'b110) begin
                    len = 2'd1;
                end
            end
            default: len = 2'd1;
        endcase
        return len;
    endfunction

    assign db_len = op_len(DB_in);

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        operand1_d  = operand1_q;
        operand2_d  = operand2_q;
        len_d       = len_q;
        ab          = {PCHin, PCLin};
        INC_en      = 1'b0;
        PCLin_en    = 1'b0;
        PCHin_en    = 1'b0;
        ADLin_en    = 1'b0;
        ADHin_en    = 1'b0;
        ADL         = 8'h00;
        ADH         = 8'h00;
        instr_valid = 1'b0;

        unique case (state_q)
            StVecLo: begin
                ab       = VecAddrLo;
                ADL      = DB_in;
                ADLin_en = 1'b1;
                PCHin_en = 1'b1;
                state_d  = StVecHi;
            end
            StVecHi: begin
                ab       = VecAddrHi;
                ADH      = DB_in;
                ADHin_en = 1'b1;
                PCLin_en = 1'b1;
                state_d  = StFetchOp;
            end
            StFetchOp: begin
                PCLin_en   = 1'b1;
                PCHin_en   = 1'b1;
                INC_en     = 1'b1;
                opcode_d   = DB_in;
                operand1_d = 8'h00;
                operand2_d = 8'h00;
                len_d      = db_len;
                state_d    = (db_len > 2'd1) ? StFetchB1 : StHold;
            end
            StFetchB1: begin
                PCLin_en   = 1'b1;
                PCHin_en   = 1'b1;
                INC_en     = 1'b1;
                operand1_d = DB_in;
                state_d    = (len_q == 2'd3) ? StFetchB2 : StHold;
            end
            StFetchB2: begin
                PCLin_en   = 1'b1;
                PCHin_en   = 1'b1;
                INC_en     = 1'b1;
                operand2_d = DB_in;
                state_d    = StHold;
            end
            StHold: begin
                instr_valid = 1'b1;
                PCLin_en    = 1'b1;
                PCHin_en    = 1'b1;
                if (instr_ready) begin
                    state_d = StFetchOp;
                    // Jump is taken only on the handshake; the PC loads the target.
                    if (jump_req) begin
                        ADL      = jump_addr[7:0];
                        ADH      = jump_addr[15:8];
                        ADLin_en = 1'b1;
                        ADHin_en = 1'b1;
                        PCLin_en = 1'b0;
                        PCHin_en = 1'b0;
                    end
                end
            end
            default: state_d = StVecLo;
        endcase

        // Reset overrides everything combinationally so the PC is left untouched.
        if (!rst) begin
            state_d     = StVecLo;
            opcode_d    = 8'h00;
            operand1_d  = 8'h00;
            operand2_d  = 8'h00;
            len_d       = 2'd1;
            ab          = VecAddrLo;
            INC_en      = 1'b0;
            PCLin_en    = 1'b0;
            PCHin_en    = 1'b0;
            ADLin_en    = 1'b0;
            ADHin_en    = 1'b0;
            ADL         = 8'h00;
            ADH         = 8'h00;
            instr_valid = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_ph2) begin
        state_q    <= state_d;
        opcode_q   <= opcode_d;
        operand1_q <= operand1_d;
        operand2_q <= operand2_d;
        len_q      <= len_d;
    end

    assign AB_lo     = ab[7:0];
    assign AB_hi     = ab[15:8];
    assign RW        = 1'b1;
    assign opcode    = opcode_q;
    assign operand1  = operand1_q;
    assign operand2  = operand2_q;
    assign instr_len = len_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural memory and program counter.
module tb_fetch_sequencer;

    logic        CLOCK_ph2 = 1'b0;
    logic        rst;
    logic [7:0]  PCLin, PCHin, DB_in;
    logic        instr_ready, jump_req;
    logic [15:0] jump_addr;
    logic [7:0]  AB_lo, AB_hi;
    logic        RW, INC_en, PCLin_en, PCHin_en, ADLin_en, ADHin_en;
    logic [7:0]  ADL, ADH;
    logic        instr_valid;
    logic [7:0]  opcode, operand1, operand2;
    logic [1:0]  instr_len;

    fetch_sequencer dut (
        .CLOCK_ph2   (CLOCK_ph2),
        .rst         (rst),
        .PCLin       (PCLin),
        .PCHin       (PCHin),
        .DB_in       (DB_in),
        .instr_ready (instr_ready),
        .jump_req    (jump_req),
        .jump_addr   (jump_addr),
        .AB_lo       (AB_lo),
        .AB_hi       (AB_hi),
        .RW          (RW),
        .INC_en      (INC_en),
        .PCLin_en    (PCLin_en),
        .PCHin_en    (PCHin_en),
        .ADLin_en    (ADLin_en),
        .ADHin_en    (ADHin_en),
        .ADL         (ADL),
        .ADH         (ADH),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .operand1    (operand1),
        .operand2    (operand2),
        .instr_len   (instr_len)
    );

    always #5 CLOCK_ph2 = ~CLOCK_ph2;

    logic [7:0]  mem [0:65535];
    logic [15:0] ab;
    logic [15:0] pc = 16'h1234;
    logic [15:0] pc_nxt;

    assign ab    = {AB_hi, AB_lo};
    assign DB_in = mem[ab];
    assign PCLin = pc[7:0];
    assign PCHin = pc[15:8];

    // Program counter model: byte loads from ADL/ADH, otherwise hold, then optional increment.
    always_comb begin
        pc_nxt = pc;
        if (ADLin_en) pc_nxt[7:0] = ADL;
        if (ADHin_en) pc_nxt[15:8] = ADH;
        if (INC_en) pc_nxt = pc_nxt + 16'd1;
    end

    always_ff @(posedge CLOCK_ph2) pc <= pc_nxt;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  op;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_ph2);
        #2;
    endtask

    task automatic put_instr(input logic [15:0] a, input logic [7:0] op, input logic [7:0] b1,
                             input logic [7:0] b2, input int len);
        exp_t e;
        mem[a] = op;
        if (len > 1) mem[a + 16'd1] = b1;
        if (len > 2) mem[a + 16'd2] = b2;
        e.addr = a;
        e.op   = op;
        e.b1   = (len > 1) ? b1 : 8'h00;
        e.b2   = (len > 2) ? b2 : 8'h00;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // Called in the FETCH_OP cycle; fetches, checks HOLD, then handshakes or resets in HOLD.
    task automatic fetch_instr(input int ready_wait, input logic do_jump,
                               input logic [15:0] target, input logic rst_in_hold);
        exp_t        e;
        int          n;
        logic [15:0] nxt;
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        nxt = e.addr + 16'(e.len);
        n = 0;
        #1;
        while (!instr_valid && n < 6) begin
            check("fetch_ab", 32'(ab), 32'(e.addr + 16'(n)));
            check("fetch_inc", 32'(INC_en), 32'd1);
            n++;
            tick();
        end
        check("latency", 32'(n), 32'(e.len));
        check("opcode", 32'(opcode), 32'(e.op));
        check("operand1", 32'(operand1), 32'(e.b1));
        check("operand2", 32'(operand2), 32'(e.b2));
        check("instr_len", 32'(instr_len), 32'(e.len));
        check("hold_ab", 32'(ab), 32'(nxt));
        check("hold_pc", 32'(pc), 32'(nxt));
        for (int i = 0; i < ready_wait; i++) begin
            jump_req  = 1'b1;
            jump_addr = 16'(32'($urandom));
            #1;
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_inc", 32'(INC_en), 32'd0);
            check("stall_adl_en", 32'(ADLin_en), 32'd0);
            check("stall_ab", 32'(ab), 32'(nxt));
            check("stall_opcode", 32'(opcode), 32'(e.op));
            tick();
            check("stall_pc", 32'(pc), 32'(nxt));
        end
        jump_req = 1'b0;
        if (rst_in_hold) begin
            rst = 1'b0;
            #1;
            check("rst_hold_valid", 32'(instr_valid), 32'd0);
            check("rst_hold_ab", 32'(ab), 32'hFFFC);
            tick();
            check("rst_hold_opcode", 32'(opcode), 32'h00);
            check("rst_hold_len", 32'(instr_len), 32'd1);
            rst = 1'b1;
            return;
        end
        instr_ready = 1'b1;
        jump_req    = do_jump;
        jump_addr   = target;
        #1;
        if (do_jump) begin
            check("jmp_en", 32'({ADLin_en, ADHin_en, PCLin_en, PCHin_en, INC_en}), 32'b11000);
            check("jmp_adl", 32'(ADL), 32'(target[7:0]));
            check("jmp_adh", 32'(ADH), 32'(target[15:8]));
        end else begin
            check("hs_en", 32'({ADLin_en, ADHin_en, PCLin_en, PCHin_en, INC_en}), 32'b00110);
            check("hs_adl", 32'(ADL), 32'h00);
        end
        tick();
        instr_ready = 1'b0;
        jump_req    = 1'b0;
    endtask

    task automatic vector_seq();
        #1;
        check("vec_lo_ab", 32'(ab), 32'hFFFC);
        check("vec_lo_en", 32'({ADLin_en, ADHin_en, PCLin_en, PCHin_en, INC_en}), 32'b10010);
        check("vec_lo_adl", 32'(ADL), 32'(mem[16'hFFFC]));
        tick();
        check("vec_hi_ab", 32'(ab), 32'hFFFD);
        check("vec_hi_en", 32'({ADLin_en, ADHin_en, PCLin_en, PCHin_en, INC_en}), 32'b01100);
        check("vec_hi_adh", 32'(ADH), 32'(mem[16'hFFFD]));
        tick();
        check("vec_pc", 32'(pc), 32'h8000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        put_instr(16'h8000, 8'hA9, 8'h42, 8'h00, 2);
        put_instr(16'h8002, 8'hAD, 8'h34, 8'h12, 3);
        put_instr(16'h8005, 8'hEA, 8'h00, 8'h00, 1);
        put_instr(16'hC123, 8'h20, 8'h11, 8'h22, 3);
        put_instr(16'hC126, 8'h0A, 8'h00, 8'h00, 1);
        put_instr(16'hC127, 8'h6C, 8'h33, 8'h44, 3);
        put_instr(16'hC12A, 8'h10, 8'h55, 8'h00, 2);
        put_instr(16'hC12C, 8'h00, 8'h00, 8'h00, 1);
        mem[16'hC12D] = 8'hAD;
        mem[16'hC12E] = 8'h56;
        mem[16'hC12F] = 8'h78;

        rst         = 1'b0;
        instr_ready = 1'b0;
        jump_req    = 1'b0;
        jump_addr   = 16'h0000;
        repeat (3) tick();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_ab", 32'(ab), 32'hFFFC);
        check("rst_en", 32'({ADLin_en, ADHin_en, PCLin_en, PCHin_en, INC_en}), 32'd0);
        check("rst_rw", 32'(RW), 32'd1);
        check("rst_len", 32'(instr_len), 32'd1);
        check("rst_opcode", 32'(opcode), 32'h00);

        rst = 1'b1;
        vector_seq();
        fetch_instr(0, 1'b0, 16'h0000, 1'b0);
        fetch_instr(5, 1'b0, 16'h0000, 1'b0);
        fetch_instr(0, 1'b1, 16'hC123, 1'b0);
        fetch_instr(0, 1'b0, 16'h0000, 1'b0);
        fetch_instr(1, 1'b0, 16'h0000, 1'b0);
        fetch_instr(0, 1'b0, 16'h0000, 1'b0);
        fetch_instr(2, 1'b0, 16'h0000, 1'b0);
        fetch_instr(0, 1'b0, 16'h0000, 1'b0);

        // Abandon a 3-byte fetch in its first operand cycle.
        #1;
        check("b1_op_ab", 32'(ab), 32'hC12D);
        tick();
        check("b1_ab", 32'(ab), 32'hC12E);
        rst = 1'b0;
        #1;
        check("rst_b1_valid", 32'(instr_valid), 32'd0);
        check("rst_b1_en", 32'({ADLin_en, ADHin_en, PCLin_en, PCHin_en, INC_en}), 32'd0);
        check("rst_b1_ab", 32'(ab), 32'hFFFC);
        tick();
        tick();
        rst = 1'b1;
        vector_seq();
        put_instr(16'h8000, 8'hA9, 8'h42, 8'h00, 2);
        fetch_instr(1, 1'b0, 16'h0000, 1'b1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
